// File: rtl/fft_cp_strip.sv
// CP removal front-end for the FFT: tracks LTE symbol/slot timing on the
// strobed sample stream, drops each cyclic prefix, buffers the useful
// samples and replays them as one contiguous clock-rate burst.
module fft_cp_strip #(
  parameter int unsigned DATA_NBIT    = 16,
  parameter int unsigned CLK_FS_RATIO = 5
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [1:0]           fft_num,
  input  logic                 cp_type,
  input  logic [DATA_NBIT-1:0] in_i,
  input  logic [DATA_NBIT-1:0] in_q,
  input  logic                 in_v,
  input  logic                 in_s,
  output logic [DATA_NBIT-1:0] out_i,
  output logic [DATA_NBIT-1:0] out_q,
  output logic                 out_h,
  output logic                 out_s,
  output logic                 out_v,
  output logic [2:0]           sym_idx,
  output logic                 resync
);

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned DEPTH  = 2048;
  localparam int unsigned WORD_W = 2 * DATA_NBIT;

  // The block is strobe-driven; any ratio of at least one clock per sample works.
  if (CLK_FS_RATIO < 1) begin : g_ratio_check
    $error("fft_cp_strip: CLK_FS_RATIO must be >= 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CP,
    ST_DATA
  } wr_state_e;

  wr_state_e         wr_state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic [2:0]        sym_q;
  logic [1:0]        fft_num_q;
  logic              cp_type_q;
  logic              done_q;
  logic [2:0]        done_sym_q;
  logic [ADDR_W-1:0] done_last_q;

  logic [ADDR_W-1:0] data_last_c;
  logic [ADDR_W-1:0] cp_last_c;
  logic [2:0]        sym_last_c;
  logic              boundary_c;
  logic              wr_en_c;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic              rd_busy_q;
  logic              rd_vld_q;
  logic              rd_en_c;
  logic [ADDR_W-1:0] rd_addr_c;

  // Segment lengths for the latched configuration; CP is not scaled by fft_num.
  always_comb begin
    data_last_c = ADDR_W'(511);
    case (fft_num_q)
      2'b00:   data_last_c = ADDR_W'(2047);
      2'b01:   data_last_c = ADDR_W'(1535);
      2'b10:   data_last_c = ADDR_W'(1023);
      default: data_last_c = ADDR_W'(511);
    endcase
    if (cp_type_q) begin
      cp_last_c = ADDR_W'(511);
    end else if (sym_q == 3'd0) begin
      cp_last_c = ADDR_W'(159);
    end else begin
      cp_last_c = ADDR_W'(143);
    end
    sym_last_c = cp_type_q ? 3'd5 : 3'd6;
  end

  // First CP sample of symbol 0 after a wrap: the only place in_s is expected.
  assign boundary_c = (cnt_q == '0) && (sym_q == 3'd0);
  assign wr_en_c    = (wr_state_q == ST_DATA) && in_v && !in_s;

  // Write-side timing FSM, advancing on each input strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_state_q  <= ST_IDLE;
      cnt_q       <= '0;
      sym_q       <= '0;
      fft_num_q   <= 2'b00;
      cp_type_q   <= 1'b0;
      done_q      <= 1'b0;
      done_sym_q  <= '0;
      done_last_q <= '0;
      resync      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      resync <= 1'b0;
      if (in_v) begin
        case (wr_state_q)
          ST_IDLE: begin
            if (in_s) begin
              fft_num_q  <= fft_num;
              cp_type_q  <= cp_type;
              sym_q      <= 3'd0;
              cnt_q      <= ADDR_W'(1);
              wr_state_q <= ST_CP;
            end
          end
          ST_CP: begin
            if (in_s && !boundary_c) begin
              resync     <= 1'b1;
              fft_num_q  <= fft_num;
              cp_type_q  <= cp_type;
              sym_q      <= 3'd0;
              cnt_q      <= ADDR_W'(1);
            end else begin
              if (in_s) begin
                fft_num_q <= fft_num;
                cp_type_q <= cp_type;
              end
              if (cnt_q == cp_last_c) begin
                cnt_q      <= '0;
                wr_state_q <= ST_DATA;
              end else begin
                cnt_q <= cnt_q + ADDR_W'(1);
              end
            end
          end
          ST_DATA: begin
            if (in_s) begin
              resync     <= 1'b1;
              fft_num_q  <= fft_num;
              cp_type_q  <= cp_type;
              sym_q      <= 3'd0;
              cnt_q      <= ADDR_W'(1);
              wr_state_q <= ST_CP;
            end else if (cnt_q == data_last_c) begin
              done_q      <= 1'b1;
              done_sym_q  <= sym_q;
              done_last_q <= data_last_c;
              sym_q       <= (sym_q == sym_last_c) ? 3'd0 : sym_q + 3'd1;
              cnt_q       <= '0;
              wr_state_q  <= ST_CP;
            end else begin
              cnt_q <= cnt_q + ADDR_W'(1);
            end
          end
          default: wr_state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Address 0 is fetched on the done clock so the burst follows the head pulse directly.
  assign rd_en_c   = done_q || rd_busy_q;
  assign rd_addr_c = done_q ? '0 : rd_ptr_q;

  // Symbol buffer: one write port from the sample stream, one registered read port.
  always_ff @(posedge clk) begin
    if (wr_en_c) begin
      mem[cnt_q] <= {in_i, in_q};
    end
    if (rd_en_c) begin
      rd_data_q <= mem[rd_addr_c];
    end
  end

  // Read-side burst sequencer and registered output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q  <= '0;
      rd_busy_q <= 1'b0;
      rd_vld_q  <= 1'b0;
      out_h     <= 1'b0;
      out_s     <= 1'b0;
      out_v     <= 1'b0;
      out_i     <= '0;
      out_q     <= '0;
      sym_idx   <= '0;
    end else begin
      out_h <= done_q;
      out_s <= done_q && (done_sym_q == 3'd0);
      if (done_q) begin
        sym_idx   <= done_sym_q;
        rd_ptr_q  <= ADDR_W'(1);
        rd_busy_q <= (done_last_q != '0);
      end else if (rd_busy_q) begin
        if (rd_ptr_q == done_last_q) begin
          rd_busy_q <= 1'b0;
        end
        rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      end
      rd_vld_q <= rd_en_c;
      out_v    <= rd_vld_q;
      if (rd_vld_q) begin
        out_i <= rd_data_q[WORD_W-1:DATA_NBIT];
        out_q <= rd_data_q[DATA_NBIT-1:0];
      end else begin
        out_i <= '0;
        out_q <= '0;
      end
    end
  end

endmodule

// File: tb/tb_fft_cp_strip.sv
// Scoreboard bench for fft_cp_strip: the stimulus generator builds LTE slots
// and queues each completed symbol's expected burst; a monitor pops and checks.
module tb_fft_cp_strip;

  localparam int unsigned DATA_NBIT = 16;

  typedef struct packed {
    logic        slot;
    logic [2:0]  sym;
    logic [11:0] len;
  } hdr_t;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [1:0]           fft_num;
  logic                 cp_type;
  logic [DATA_NBIT-1:0] in_i;
  logic [DATA_NBIT-1:0] in_q;
  logic                 in_v;
  logic                 in_s;
  logic [DATA_NBIT-1:0] out_i;
  logic [DATA_NBIT-1:0] out_q;
  logic                 out_h;
  logic                 out_s;
  logic                 out_v;
  logic [2:0]           sym_idx;
  logic                 resync;

  hdr_t        hdr_q[$];
  logic [31:0] exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          rem = 0;
  int          resync_cnt = 0;
  int          samp_idx = 0;

  fft_cp_strip #(.DATA_NBIT(DATA_NBIT), .CLK_FS_RATIO(5)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .fft_num (fft_num),
    .cp_type (cp_type),
    .in_i    (in_i),
    .in_q    (in_q),
    .in_v    (in_v),
    .in_s    (in_s),
    .out_i   (out_i),
    .out_q   (out_q),
    .out_h   (out_h),
    .out_s   (out_s),
    .out_v   (out_v),
    .sym_idx (sym_idx),
    .resync  (resync)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Sample pattern: 0 = index ramp, 1 = impulse at data index 8, 2 = random.
  function automatic logic [31:0] gen(input int mode, input int k);
    logic [15:0] idx;
    idx = samp_idx[15:0];
    case (mode)
      0:       return {idx, ~idx};
      1:       return (k == 8) ? {16'h7fff, 16'h0000} : 32'h0;
      default: return $urandom;
    endcase
  endfunction

  task automatic drive(input logic s, input logic [31:0] w, input int ratio);
    in_v = 1'b1;
    in_s = s;
    in_i = w[31:16];
    in_q = w[15:0];
    @(posedge clk); #1;
    in_v = 1'b0;
    in_s = 1'b0;
    samp_idx++;
    for (int r = 1; r < ratio; r++) begin
      @(posedge clk); #1;
    end
  endtask

  // Drive one slot (optionally truncated or aborted) and queue expected bursts.
  task automatic run_slot(input logic [1:0] fn, input logic ct, input int ratio,
                          input int mode, input int nsym_lim, input int abort_sym,
                          input int abort_k, input logic send_s);
    int          nsym;
    int          len;
    int          cpl;
    logic [31:0] w;
    logic [31:0] sbuf[$];
    hdr_t        h;
    fft_num = fn;
    cp_type = ct;
    nsym = ct ? 6 : 7;
    if (nsym_lim < nsym) nsym = nsym_lim;
    len = (4 - int'(fn)) * 512;
    for (int s = 0; s < nsym; s++) begin
      cpl = ct ? 512 : ((s == 0) ? 160 : 144);
      for (int c = 0; c < cpl; c++) begin
        w = gen(mode, -1);
        drive(send_s && (s == 0) && (c == 0), w, ratio);
        if (s == 0 && c == 0) begin
          fft_num = ~fn;
          cp_type = ~ct;
        end
      end
      sbuf.delete();
      for (int k = 0; k < len; k++) begin
        if (s == abort_sym && k == abort_k) return;
        w = gen(mode, k);
        sbuf.push_back(w);
        if (k == len - 1) begin
          h.slot = (s == 0);
          h.sym  = 3'(s);
          h.len  = 12'(len);
          hdr_q.push_back(h);
          foreach (sbuf[j]) exp_q.push_back(sbuf[j]);
        end
        drive(1'b0, w, ratio);
      end
    end
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      if (hdr_q.size() == 0 && exp_q.size() == 0 && rem == 0) break;
    end
    check("drain_hdr", hdr_q.size(), 0);
    check("drain_data", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    in_v = 1'b0;
    in_s = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic check_outputs_zero(input string pfx);
    check({pfx, "_v"}, out_v, 0);
    check({pfx, "_h"}, out_h, 0);
    check({pfx, "_s"}, out_s, 0);
    check({pfx, "_i"}, out_i, 0);
    check({pfx, "_q"}, out_q, 0);
    check({pfx, "_sym"}, sym_idx, 0);
    check({pfx, "_resync"}, resync, 0);
  endtask

  // Output monitor: header on out_h, then exactly len contiguous valid samples.
  always @(negedge clk) begin
    hdr_t        h;
    logic [31:0] e;
    if (!reset_n) begin
      rem = 0;
    end else begin
      if (resync) resync_cnt++;
      if (out_h) begin
        if (rem != 0) check("h_in_burst", rem, 0);
        check("h_v", out_v, 0);
        if (hdr_q.size() == 0) begin
          check("hdr_unexp", 1, 0);
        end else begin
          h = hdr_q.pop_front();
          check("sym_idx", sym_idx, h.sym);
          check("out_s", out_s, h.slot);
          rem = int'(h.len);
        end
      end else begin
        if (out_s) check("stray_s", out_s, 0);
        if (rem > 0) begin
          check("out_v", out_v, 1);
          if (exp_q.size() == 0) begin
            check("data_unexp", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("out_i", out_i, e[31:16]);
            check("out_q", out_q, e[15:0]);
          end
          rem--;
        end else if (out_v) begin
          check("stray_v", out_v, 0);
        end else if (out_i != 0 || out_q != 0) begin
          check("idle_data", {out_i, out_q}, 0);
        end
      end
    end
  end

  initial begin
    int r0;
    bit got_h;
    fft_num = 2'b00;
    cp_type = 1'b0;
    in_i = '0;
    in_q = '0;
    in_v = 1'b0;
    in_s = 1'b0;
    reset_n = 1'b0;
    #12;
    check_outputs_zero("rst");
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Normal CP, 2048, full slot with index ramp, then an on-time slot start.
    samp_idx = 0;
    run_slot(2'b00, 1'b0, 2, 0, 7, -1, 0, 1'b1);
    wait_drain();
    run_slot(2'b00, 1'b0, 1, 2, 3, -1, 0, 1'b1);
    wait_drain();
    check("no_resync_a", resync_cnt, 0);

    // Extended CP, 512: full slot then a slot with its in_s missing.
    do_reset();
    run_slot(2'b11, 1'b1, 1, 0, 6, -1, 0, 1'b1);
    run_slot(2'b11, 1'b1, 1, 0, 1, -1, 0, 1'b0);
    wait_drain();
    check("no_resync_b", resync_cnt, 0);

    // Impulse at data index 8, 1024-point.
    do_reset();
    run_slot(2'b10, 1'b0, 1, 1, 7, -1, 0, 1'b1);
    wait_drain();

    // Unexpected in_s at data sample 300 of symbol 2.
    do_reset();
    r0 = resync_cnt;
    run_slot(2'b00, 1'b0, 1, 0, 7, 2, 300, 1'b1);
    run_slot(2'b00, 1'b0, 1, 0, 1, -1, 0, 1'b1);
    wait_drain();
    check("resync_once", resync_cnt - r0, 1);

    // Reset 1000 clocks into a burst, then idle samples without in_s.
    do_reset();
    run_slot(2'b00, 1'b0, 1, 0, 1, -1, 0, 1'b1);
    got_h = 1'b0;
    for (int i = 0; i < 20 && !got_h; i++) begin
      @(negedge clk);
      got_h = out_h;
    end
    check("h_timeout", got_h, 1);
    repeat (1000) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check_outputs_zero("mid_rst");
    hdr_q.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 0; i < 1000; i++) drive(1'b0, gen(0, -1), 1);
    run_slot(2'b00, 1'b0, 1, 0, 1, -1, 0, 1'b1);
    wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_cp_strip.md
Name: fft_cp_strip

Overview:
- Sits directly upstream of the FFT core input; consumes the baseband sample stream at sample rate fs, one strobe every CLK_FS_RATIO clocks, with CP included.
- Tracks LTE symbol/slot timing and discards each cyclic prefix.
- Buffers the fft_len useful samples of each symbol, then replays them as one contiguous clock-rate burst with symbol-head/slot-start flags.
- The output burst is the FFT input format: head pulse, then fft_len contiguous valids.

Parameters:
- DATA_NBIT, 16, I/Q sample width.
- CLK_FS_RATIO, 5, nominal clocks per input sample. Informational only: the block is strobe-driven and correct for any ratio >= 1.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- fft_num  in  2  00=2048, 01=1536, 10=1024, 11=512; fft_len = (4-fft_num)*512
- cp_type  in  1  0=normal CP, 1=extended CP
- in_i  in  DATA_NBIT  input I sample
- in_q  in  DATA_NBIT  input Q sample
- in_v  in  1  input sample strobe, at most one per clock
- in_s  in  1  slot start; qualified by in_v; marks the first CP sample of symbol 0
- out_i  out  DATA_NBIT  burst I sample
- out_q  out  DATA_NBIT  burst Q sample
- out_h  out  1  one-clock symbol-head pulse
- out_s  out  1  one-clock slot-start pulse, coincident with out_h of symbol 0
- out_v  out  1  burst valid, fft_len contiguous clocks
- sym_idx  out  3  symbol index of current/last burst (0..6 normal, 0..5 extended)
- resync  out  1  one-clock pulse on unexpected in_s

Behaviour:
- Reset (asynchronous, reset_n=0): all outputs 0; state IDLE; counters 0; latched config = 2048/normal.
- CP lengths from the codebase include: `CP_NOR_FST_NUM` (160, symbol 0, normal), `CP_NOR_NUM` (144, symbols 1..6, normal), `CP_EXT_NUM` (512, all extended). They are not scaled by fft_num.
- Write-side FSM, advancing only on in_v:
  - IDLE: all in_v ignored until in_v&in_s. On that event: latch fft_num/cp_type, set sym=0, count that sample as CP sample 0, go to CP.
  - CP: count cp_len samples and discard them; the sample after the last CP sample is the first DATA sample.
  - DATA: write sample k (0..fft_len-1) to buffer address k. After sample fft_len-1: raise internal done and increment sym. sym wraps 6->0 (normal) or 5->0 (extended). Go to CP.
  - At wrap to sym 0, the next in_s is expected on the first CP sample of the new slot. Config is re-latched only there.
- in_s with in_v at any other point (mid-CP, mid-DATA, or early/late at the boundary):
  - Pulse resync.
  - Abandon the partial symbol; no burst is issued for it.
  - Restart as CP sample 0 of symbol 0 with newly latched config.
- A missing in_s at the expected boundary is not an error; counting continues.
- Buffer: single dual-port RAM, 2048 x 2*DATA_NBIT, with 1-clock read latency.
- Read side:
  - On the clock after done: out_h=1, and out_s=1 if the finished symbol is sym 0. sym_idx updates with it.
  - The following fft_len clocks: out_v=1, out_i/out_q = buffer[0..fft_len-1] in order.
  - out_i/out_q = 0 whenever out_v=0.
- Overlap safety: the burst lasts fft_len clocks. The next symbol's DATA writes begin at least cp_len strobes after done, so the read pointer always leads. No overwrite is possible for CLK_FS_RATIO >= 1.
- A resync during an active burst does not truncate the burst; it completes.
- Simultaneous done and resync is impossible: the resync sample becomes a CP sample.
- fft_num/cp_type changes outside latch points are ignored.

Test Plan:
- Normal CP, fft_num=00, ratio 5, full slot with in_i=sample index mod 2^16:
  - Exactly 7 bursts of 2048 out_v each; out_s only on the first; sym_idx 0..6.
  - Burst 0 out_i = 160..2207; burst 1 out_i = first data sample after the 144-sample CP.
- Extended CP, fft_num=11 (512):
  - 6 bursts per slot; each burst 512 clocks; 512 samples discarded per symbol; sym_idx wraps 5->0.
- Impulse at data index 8 (in_i=32767, else 0), fft_num=10: out_i=32767 on exactly the 9th out_v clock of each burst; 0 elsewhere.
- in_s injected at DATA sample 300 of symbol 2:
  - resync pulses once; no burst for symbol 2.
  - Next burst has out_s=1, sym_idx=0, and starts after 160 CP samples.
- reset_n deasserted mid-burst (clock 1000 of 2048): all outputs 0 immediately; no further out_v until a new in_s plus CP plus 2048 samples.
- CLK_FS_RATIO=1 (in_v every clock), normal CP: bursts are bit-exact with the written data; no corruption from concurrent writes of the next symbol.
